// File: rtl/cmd_pwm_pkg.sv
// Shared types and helpers for the command-driven PWM generator.
package cmd_pwm_pkg;

   typedef logic [6:0] duty_t;

   localparam int unsigned PWM_STEPS = 100;
   localparam int unsigned DIGIT_MAX = 9;

   typedef struct packed {
      logic  valid;
      duty_t duty;
   } cmd_dec_t;

   // Duty is only meaningful when valid; out-of-range digits are truncated harmlessly.
   function automatic cmd_dec_t digits_to_duty(input logic [7:0] tens, input logic [7:0] ones);
      cmd_dec_t r;
      r.valid = (tens <= 8'(DIGIT_MAX)) && (ones <= 8'(DIGIT_MAX));
      r.duty  = duty_t'(tens) * 7'd10 + duty_t'(ones);
      return r;
   endfunction

endpackage

// File: rtl/cmd_pwm_gen_tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 500
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count <= '0;
      else if (tick) count <= '0;
      else           count <= count + 1'b1;
   end

endmodule

// File: rtl/cmd_pwm_gen.sv
// Decimal-digit motor command to slew-limited 100-step PWM.
// Optional command watchdog compiled in with CMD_WDOG_EN.
module cmd_pwm_gen
   import cmd_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE     = 500,
   parameter int unsigned MAX_STEP     = 5,
   parameter int unsigned WDOG_PERIODS = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [15:0] cmd,
   output logic        pwm_out,
   output logic [6:0]  duty_o,
   output logic [6:0]  target_o,
   output logic        ramping,
   output logic        cmd_err,
   output logic        wdog_trip
);

   localparam duty_t LAST_STEP  = duty_t'(PWM_STEPS - 1);
   localparam duty_t MAX_STEP_D = duty_t'(MAX_STEP);

   logic     tick;
   logic     boundary;
   duty_t    step;
   duty_t    target;
   duty_t    active;
   duty_t    next_active;
   duty_t    diff;
   cmd_dec_t dec;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   assign dec      = digits_to_duty(cmd[15:8], cmd[7:0]);
   assign boundary = tick && (step == LAST_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    step <= '0;
      else if (tick) step <= (step == LAST_STEP) ? '0 : step + 1'b1;
   end

   always_comb begin
      next_active = active;
      diff        = '0;
      if (target > active) begin
         diff        = target - active;
         next_active = (diff <= MAX_STEP_D) ? target : active + MAX_STEP_D;
      end else if (target < active) begin
         diff        = active - target;
         next_active = (diff <= MAX_STEP_D) ? target : active - MAX_STEP_D;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= '0;
         pwm_out <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         if (boundary) active <= next_active;
         pwm_out <= (step < active);
         cmd_err <= cmd_valid && !dec.valid;
      end
   end

`ifdef CMD_WDOG_EN
   localparam int unsigned WW = $clog2(WDOG_PERIODS + 1);
   localparam logic [WW-1:0] WDOG_LIMIT = WW'(WDOG_PERIODS);

   logic [WW-1:0] wdog_cnt;

   // Trip is taken on the boundary that brings the count to the limit, so the
   // flag is visible right after that boundary; a valid command always wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target    <= '0;
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else if (cmd_valid && dec.valid) begin
         target    <= dec.duty;
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else if (boundary && (wdog_cnt != WDOG_LIMIT)) begin
         wdog_cnt <= wdog_cnt + 1'b1;
         if (wdog_cnt == WDOG_LIMIT - 1'b1) begin
            target    <= '0;
            wdog_trip <= 1'b1;
         end
      end
   end
`else
   logic unused_wdog_param;

   assign unused_wdog_param = (WDOG_PERIODS == 0);
   assign wdog_trip         = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    target <= '0;
      else if (cmd_valid && dec.valid) target <= dec.duty;
   end
`endif

   assign duty_o   = active;
   assign target_o = target;
   assign ramping  = (active != target);

endmodule

// File: tb/tb_cmd_pwm_gen.sv
// Directed bench for cmd_pwm_gen (PRESCALE=2, MAX_STEP=5); CMD_WDOG_EN selects the watchdog scenario.
module tb_cmd_pwm_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd = '0;
   logic        pwm_out;
   logic [6:0]  duty_o;
   logic [6:0]  target_o;
   logic        ramping;
   logic        cmd_err;
   logic        wdog_trip;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          hi;

   localparam int unsigned PERIOD_CYC = 200;

   cmd_pwm_gen #(
      .PRESCALE    (2),
      .MAX_STEP    (5),
      .WDOG_PERIODS(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd      (cmd),
      .pwm_out  (pwm_out),
      .duty_o   (duty_o),
      .target_o (target_o),
      .ramping  (ramping),
      .cmd_err  (cmd_err),
      .wdog_trip(wdog_trip)
   );

   always #5 clk = ~clk;

   // Edges since reset release; boundaries fall on every 200th edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic to_boundary();
      do step_clk(1); while (cyc % PERIOD_CYC != 0);
   endtask

   task automatic send(input logic [7:0] tens, input logic [7:0] ones);
      cmd       = {tens, ones};
      cmd_valid = 1'b1;
      step_clk(1);
      cmd_valid = 1'b0;
   endtask

   task automatic count_period(output int n);
      n = 0;
      for (int i = 0; i < int'(PERIOD_CYC); i++) begin
         step_clk(1);
         if (pwm_out === 1'b1) n++;
      end
   endtask

   initial begin
      step_clk(3);
      check("rst_pwm", pwm_out, 0);
      check("rst_duty", duty_o, 0);
      check("rst_target", target_o, 0);
      check("rst_ramping", ramping, 0);
      check("rst_cmd_err", cmd_err, 0);
      check("rst_wdog", wdog_trip, 0);

      @(negedge clk);
      rst_n = 1'b1;

`ifdef CMD_WDOG_EN
      send(8'd2, 8'd0);
      to_boundary(); check("wd_ramp5", duty_o, 5);
      to_boundary(); check("wd_ramp10", duty_o, 10);
      send(8'd2, 8'd0);
      to_boundary(); check("wd_ramp15", duty_o, 15);
      to_boundary(); check("wd_ramp20", duty_o, 20);
      send(8'd2, 8'd0);
      to_boundary(); check("wd_b1_trip", wdog_trip, 0);
      to_boundary(); check("wd_b2_trip", wdog_trip, 0);
      to_boundary();
      check("wd_b3_trip", wdog_trip, 1);
      check("wd_b3_target", target_o, 0);
      check("wd_b3_duty", duty_o, 20);
      for (int d = 15; d >= 0; d -= 5) begin
         to_boundary();
         check("wd_down", duty_o, d);
      end
      send(8'd0, 8'd12);
      check("wd_inv_err", cmd_err, 1);
      check("wd_inv_trip", wdog_trip, 1);
      send(8'd0, 8'd7);
      check("wd_clr_trip", wdog_trip, 0);
      check("wd_clr_target", target_o, 7);
`else
      send(8'd4, 8'd2);
      check("t42_target", target_o, 42);
      check("t42_duty", duty_o, 0);
      check("t42_ramping", ramping, 1);
      check("t42_err", cmd_err, 0);
      for (int d = 5; d <= 42; d += 5) begin
         to_boundary();
         check("up_duty", duty_o, d);
      end
      check("up_ramping40", ramping, 1);
      to_boundary();
      check("up_duty42", duty_o, 42);
      check("up_ramping42", ramping, 0);
      count_period(hi);
      check("pwm42_high", hi, 84);

      send(8'd1, 8'd10);
      check("inv_err", cmd_err, 1);
      check("inv_target", target_o, 42);
      step_clk(1);
      check("inv_err_clear", cmd_err, 0);
      to_boundary();
      check("inv_duty", duty_o, 42);
      count_period(hi);
      check("inv_pwm_high", hi, 84);

      send(8'd0, 8'd0);
      check("zero_target", target_o, 0);
      for (int d = 37; d >= 2; d -= 5) begin
         to_boundary();
         check("down_duty", duty_o, d);
      end
      to_boundary();
      check("down_duty0", duty_o, 0);
      count_period(hi);
      check("pwm0_high", hi, 0);

      send(8'd9, 8'd9);
      check("t99_target", target_o, 99);
      for (int d = 5; d <= 95; d += 5) begin
         to_boundary();
         check("up99_duty", duty_o, d);
      end
      to_boundary();
      check("up99_duty99", duty_o, 99);
      count_period(hi);
      check("pwm99_high", hi, 198);

      send(8'd5, 8'd0);
      to_boundary();
      check("sim_pre", duty_o, 94);
      do step_clk(1); while (cyc % PERIOD_CYC != PERIOD_CYC - 1);
      send(8'd9, 8'd9);
      check("sim_old_target", duty_o, 89);
      check("sim_new_target", target_o, 99);
      to_boundary();
      check("sim_next", duty_o, 94);

      step_clk(50);
      check("mid_pwm_before", pwm_out, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pwm", pwm_out, 0);
      check("arst_duty", duty_o, 0);
      check("arst_target", target_o, 0);
      check("arst_ramping", ramping, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'd1, 8'd0);
      check("rel_duty", duty_o, 0);
      to_boundary();
      check("rel_first_boundary", duty_o, 5);
      check("no_wdog", wdog_trip, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmd_pwm_gen.md
Name: cmd_pwm_gen

Overview:
Downstream consumer of the UART command interpreter's 16-bit motor commands (mgu/gnu). Each command is two bytes, each holding a decimal digit value. The block validates the command and converts it to a duty value in the range 0..99. It then drives a slew-limited 100-step PWM output, updating duty only at PWM period boundaries. One instance is placed per command channel.

Parameters:
PRESCALE, 500, clk cycles per PWM step (50 MHz clk -> 1 kHz PWM period).
MAX_STEP, 5, maximum change in active duty per PWM period; range 1..99.
WDOG_PERIODS, 1000, PWM periods without a valid command before a watchdog trip (only used with CMD_WDOG_EN).

Ports:
clk        input   1   system clock
rst_n      input   1   asynchronous active-low reset
cmd_valid  input   1   single-cycle strobe; cmd is valid while high
cmd        input   16  {tens digit value [15:8], ones digit value [7:0]}
pwm_out    output  1   registered PWM output
duty_o     output  7   currently applied duty, 0..99
target_o   output  7   commanded target duty, 0..99
ramping    output  1   high while duty_o != target_o
cmd_err    output  1   one-cycle pulse when a command is rejected
wdog_trip  output  1   watchdog tripped; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all outputs 0; prescaler, step counter, target, active duty and watchdog counter all cleared to 0.
- Command decode:
  - On a cycle with cmd_valid=1, the command is valid iff cmd[15:8] <= 9 and cmd[7:0] <= 9.
  - Valid: target <= cmd[15:8]*10 + cmd[7:0], using 7-bit unsigned arithmetic. target_o updates 1 cycle after the strobe.
  - Invalid: target is unchanged, and cmd_err pulses high for exactly 1 cycle, 1 cycle after the strobe.
  - Back-to-back strobes are each processed; the last valid command wins.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 on the cycle its count equals PRESCALE-1.
- Step counter: advances on tick over 0..99 and wraps to 0. A period boundary is a tick while step==99.
- Slew, evaluated at each boundary:
  - If |target - active| <= MAX_STEP, then active <= target.
  - Otherwise active moves toward target by exactly MAX_STEP.
  - No overshoot, no wrap; active stays within 0..99.
- Simultaneous events: if cmd_valid lands in the same cycle as a boundary, the slew uses the pre-update target. The new target is applied at the next boundary; there is no bypass.
- pwm_out: registered as (step < active), giving 1 cycle of latency from step. duty 0 is constant low; duty 99 is high for 99 of every 100 steps.
- ramping: combinational (active != target).
- Reset mid-period: all activity stops immediately. pwm_out goes low asynchronously. After release, the block restarts at step 0 with duty 0.

Optional Feature:
CMD_WDOG_EN
- Enabled:
  - A period counter increments at each boundary and clears on any valid command.
  - When it reaches WDOG_PERIODS: target <= 0, wdog_trip <= 1, and the counter holds.
  - The slew then ramps active down to 0.
  - wdog_trip clears on the next valid command, in the same cycle that target updates.
  - Invalid commands do not clear the watchdog.
- Disabled: no counter logic; wdog_trip is tied to 0; target holds indefinitely.

Decomposition:
- Package cmd_pwm_pkg:
  - duty_t (7-bit unsigned)
  - PWM_STEPS = 100
  - DIGIT_MAX = 9
  - function digits_to_duty, returning the valid flag and the duty.
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, rst_n, tick) generates the step enable. It is reusable by other timed stages.
- The remainder of the block stays in cmd_pwm_gen.

Test Plan:
All scenarios use PRESCALE=2 and MAX_STEP=5.
- Reset, then cmd={8'd4,8'd2} -> target_o=42 after 1 cycle; duty_o goes 5,10,...,40,42 at successive boundaries; ramping drops after the 42 boundary; pwm_out high for 42 of 100 steps.
- cmd={8'd1,8'd10} -> cmd_err pulses 1 cycle; target_o unchanged; no change in pwm_out.
- From duty 42, cmd={8'd0,8'd0} -> duty_o goes 37,32,...,2,0; pwm_out is then constant low. cmd={8'd9,8'd9} -> duty ramps to 99; pwm_out low exactly 1 step per period.
- cmd_valid asserted in the exact boundary cycle -> that boundary uses the old target and the next boundary uses the new one. Also assert rst_n=0 mid-ramp -> all outputs go to 0 immediately.
- CMD_WDOG_EN, WDOG_PERIODS=3, duty 20 -> after 3 boundaries with no command, wdog_trip=1 and duty ramps to 0. A valid cmd {0,7} clears wdog_trip and sets target_o=7. An invalid cmd does not clear wdog_trip.
